// File: rtl/tpu_seq_pkg.sv
// rtl/tpu_seq_pkg.sv - shared types and helpers for the TPU tile sequencer
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int WLOAD_CYC = 2;

  // Cycles from a tile's WADDR to the cycle holding its last result write
  function automatic int tile_period(input int rows, input int array_lat);
    return WLOAD_CYC + rows + array_lat;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - DEPTH-cycle 1-bit valid shift line with synchronous clear
module valid_delay_line #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  if (DEPTH == 1) begin : g_one
    logic sr;
    always_ff @(posedge clk) begin
      if (clr) sr <= 1'b0;
      else     sr <= din;
    end
    assign dout = sr;
  end else begin : g_multi
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk) begin
      if (clr) sr <= '0;
      else     sr <= {sr[DEPTH-2:0], din};
    end
    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/tpu_tile_sequencer.sv
// rtl/tpu_tile_sequencer.sv - multi-tile weight-load / stream / drain controller
module tpu_tile_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int W_ADDR_W  = 4,
  parameter int MAX_TILES = 16,
  parameter int MAX_ROWS  = 256,
  parameter int ARRAY_LAT = 64,
  parameter int TILE_W    = $clog2(MAX_TILES + 1),
  parameter int ROW_W     = $clog2(MAX_ROWS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [TILE_W-1:0]   cfg_num_tiles,
  input  logic [ROW_W-1:0]    cfg_rows,
  input  logic [ADDR_W-1:0]   cfg_ub_base,
  input  logic [ADDR_W-1:0]   cfg_res_base,
  input  logic [W_ADDR_W-1:0] cfg_w_base,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic                w_load,
  output logic                ub_rd_en,
  output logic [ADDR_W-1:0]   ub_addr,
  output logic                res_we,
  output logic [ADDR_W-1:0]   res_addr,
  output logic [TILE_W-1:0]   tile_idx
);

  seq_state_t          state;
  logic [TILE_W-1:0]   num_tiles_q;
  logic [ROW_W-1:0]    rows_q;
  logic [W_ADDR_W-1:0] w_base_q;
  logic [ROW_W-1:0]    rd_cnt;
  logic [ROW_W-1:0]    wr_cnt;
  logic                abort_hit;
  logic                line_clr;

  assign abort_hit = abort && (state != S_IDLE);
  assign line_clr  = rst || abort_hit;

  valid_delay_line #(.DEPTH(ARRAY_LAT)) u_res_we_line (
    .clk  (clk),
    .clr  (line_clr),
    .din  (ub_rd_en),
    .dout (res_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      w_addr      <= '0;
      w_load      <= 1'b0;
      ub_rd_en    <= 1'b0;
      ub_addr     <= '0;
      res_addr    <= '0;
      tile_idx    <= '0;
      num_tiles_q <= '0;
      rows_q      <= '0;
      w_base_q    <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else if (abort_hit) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      w_load   <= 1'b0;
      ub_rd_en <= 1'b0;
      tile_idx <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      w_load  <= 1'b0;
      // Both pointers advance after each strobe and run on across tiles
      if (ub_rd_en) ub_addr <= ub_addr + ADDR_W'(1);
      if (res_we) begin
        res_addr <= res_addr + ADDR_W'(1);
        wr_cnt   <= wr_cnt + ROW_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (cfg_num_tiles == '0 || cfg_rows == '0) begin
              cfg_err <= 1'b1;
            end else begin
              num_tiles_q <= cfg_num_tiles;
              rows_q      <= cfg_rows;
              w_base_q    <= cfg_w_base;
              w_addr      <= cfg_w_base;
              ub_addr     <= cfg_ub_base;
              res_addr    <= cfg_res_base;
              tile_idx    <= '0;
              wr_cnt      <= '0;
              busy        <= 1'b1;
              state       <= S_WADDR;
            end
          end
        end
        S_WADDR: begin
          w_load <= 1'b1;
          state  <= S_WLOAD;
        end
        S_WLOAD: begin
          ub_rd_en <= 1'b1;
          rd_cnt   <= ROW_W'(1);
          state    <= S_STREAM;
        end
        S_STREAM: begin
          // rd_cnt counts reads already issued, including the current one
          if (rd_cnt == rows_q) begin
            ub_rd_en <= 1'b0;
            state    <= S_DRAIN;
          end else begin
            rd_cnt <= rd_cnt + ROW_W'(1);
          end
        end
        S_DRAIN: begin
          if (res_we && (wr_cnt == rows_q - ROW_W'(1))) begin
            wr_cnt <= '0;
            if (tile_idx == num_tiles_q - TILE_W'(1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              tile_idx <= tile_idx + TILE_W'(1);
              w_addr   <= w_base_q + W_ADDR_W'(tile_idx + TILE_W'(1));
              state    <= S_WADDR;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb/tb_tpu_tile_sequencer.sv - directed self-checking bench for tpu_tile_sequencer
module tb_tpu_tile_sequencer;
  import tpu_seq_pkg::*;

  localparam int ADDR_W    = 4;
  localparam int W_ADDR_W  = 4;
  localparam int MAX_TILES = 16;
  localparam int MAX_ROWS  = 256;
  localparam int LAT       = 8;
  localparam int TILE_W    = $clog2(MAX_TILES + 1);
  localparam int ROW_W     = $clog2(MAX_ROWS + 1);
  localparam int AMOD      = 1 << ADDR_W;
  localparam int WMOD      = 1 << W_ADDR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic [TILE_W-1:0]   cfg_num_tiles;
  logic [ROW_W-1:0]    cfg_rows;
  logic [ADDR_W-1:0]   cfg_ub_base;
  logic [ADDR_W-1:0]   cfg_res_base;
  logic [W_ADDR_W-1:0] cfg_w_base;
  logic                busy;
  logic                done;
  logic                cfg_err;
  logic [W_ADDR_W-1:0] w_addr;
  logic                w_load;
  logic                ub_rd_en;
  logic [ADDR_W-1:0]   ub_addr;
  logic                res_we;
  logic [ADDR_W-1:0]   res_addr;
  logic [TILE_W-1:0]   tile_idx;

  int n_checks = 0;
  int n_pass   = 0;

  tpu_tile_sequencer #(
    .ADDR_W    (ADDR_W),
    .W_ADDR_W  (W_ADDR_W),
    .MAX_TILES (MAX_TILES),
    .MAX_ROWS  (MAX_ROWS),
    .ARRAY_LAT (LAT),
    .TILE_W    (TILE_W),
    .ROW_W     (ROW_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_num_tiles (cfg_num_tiles),
    .cfg_rows      (cfg_rows),
    .cfg_ub_base   (cfg_ub_base),
    .cfg_res_base  (cfg_res_base),
    .cfg_w_base    (cfg_w_base),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .w_addr        (w_addr),
    .w_load        (w_load),
    .ub_rd_en      (ub_rd_en),
    .ub_addr       (ub_addr),
    .res_we        (res_we),
    .res_addr      (res_addr),
    .tile_idx      (tile_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] flags();
    return 32'({busy, w_load, ub_rd_en, res_we, done, cfg_err});
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, cfg_err, w_addr, w_load, ub_rd_en, ub_addr, res_we, res_addr, tile_idx});
  endfunction

  task automatic set_cfg(input int n, input int r, input int ubb, input int resb, input int wb);
    cfg_num_tiles = TILE_W'(n);
    cfg_rows      = ROW_W'(r);
    cfg_ub_base   = ADDR_W'(ubb);
    cfg_res_base  = ADDR_W'(resb);
    cfg_w_base    = W_ADDR_W'(wb);
  endtask

  // Start at the current cycle (cycle 0) and check every cycle against the expected schedule
  task automatic run_job(input int n, input int r, input int ubb, input int resb,
                         input int wb, input int restart_cyc);
    int p, last, t, off;
    logic e_busy, e_done, e_wl, e_rd, e_we;
    p    = tile_period(r, LAT);
    last = 1 + n * p;
    set_cfg(n, r, ubb, resb, wb);
    start = 1'b1;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == restart_cyc) begin
        start = 1'b1;
        set_cfg(5, 1, 7, 9, 3);
      end
      if (c == restart_cyc + 1) start = 1'b0;
      e_busy = (c <= last);
      e_done = (c == last);
      e_wl = 1'b0; e_rd = 1'b0; e_we = 1'b0; t = 0; off = 0;
      if (c < last) begin
        t    = (c - 1) / p;
        off  = (c - 1) % p;
        e_wl = (off == 1);
        e_rd = (off >= 2) && (off < 2 + r);
        e_we = (off >= 2 + LAT);
      end
      chk("job_flags", flags(), 32'({e_busy, e_wl, e_rd, e_we, e_done, 1'b0}));
      if (e_wl) begin
        chk("w_addr", 32'(w_addr), 32'((wb + t) % WMOD));
        chk("tile_idx", 32'(tile_idx), 32'(t));
      end
      if (e_rd) chk("ub_addr", 32'(ub_addr), 32'((ubb + t * r + off - 2) % AMOD));
      if (e_we) chk("res_addr", 32'(res_addr), 32'((resb + t * r + off - 2 - LAT) % AMOD));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-tile job, then address wrap, then weight-address wrap
    run_job(2, 3, 0, 0, 0, 0);
    run_job(1, 4, 14, 15, 0, 0);
    run_job(2, 2, 5, 9, 15, 0);

    // Bad config: N=0 then R=0
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_cfg(0, 3, 1, 1, 1);
      else        set_cfg(2, 0, 1, 1, 1);
      start = 1'b1;
      @(negedge clk);
      chk("cfg_err_pulse", flags(), 32'b000001);
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("cfg_err_quiet", flags(), 32'd0);
      end
    end

    // abort together with start in IDLE: start ignored
    set_cfg(1, 2, 0, 0, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", flags(), 32'd0);
    @(negedge clk);
    chk("abort_start_idle2", flags(), 32'd0);

    // start while busy, issued during DRAIN of tile 0
    run_job(2, 3, 0, 0, 0, 8);

    // Abort in DRAIN with results pending
    set_cfg(2, 3, 0, 0, 0);
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 9) abort = 1'b1;
      if (c == 10) abort = 1'b0;
      if (c == 9) chk("pre_abort_busy", 32'(busy), 32'd1);
      if (c >= 10) chk("post_abort", flags(), 32'd0);
    end
    run_job(1, 2, 3, 5, 2, 0);

    // Reset mid-STREAM
    set_cfg(1, 4, 0, 0, 0);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 4) begin
        chk("pre_rst_stream", 32'(ub_rd_en), 32'd1);
        rst = 1'b1;
      end
      if (c == 5) begin
        rst = 1'b0;
        chk("rst_outs", all_outs(), 32'd0);
      end
      if (c > 5) chk("post_rst", flags(), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
